// File: rtl/rf_wb_arbiter_if.sv
`default_nettype none
// =============================================================================
// Module      : rf_wb_arbiter_if
// Description : Write-back, issue and hazard signals between the ALU/load
//               sources, decode stage and register-file write port.
// Revision    : 1.0
// =============================================================================
interface rf_wb_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_rd;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_rd;
    logic [ADDR_W-1:0] Rs;
    logic [ADDR_W-1:0] Rt;
    logic              hazard_s;
    logic              hazard_t;
    logic [ADDR_W-1:0] Rd;
    logic [DATA_W-1:0] RW;
    logic              wr;
    logic              sb_err;

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output ld_valid, ld_rd, ld_data,
        input  ld_ready,
        output iss_valid, iss_rd, Rs, Rt,
        input  hazard_s, hazard_t, Rd, RW, wr, sb_err
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  ld_valid, ld_rd, ld_data,
        output ld_ready,
        input  iss_valid, iss_rd, Rs, Rt,
        output hazard_s, hazard_t, Rd, RW, wr, sb_err
    );
endinterface
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : rf_wb_arbiter
// Description : Round-robin write-back arbiter (ALU / load) with a per-register
//               busy scoreboard for read-after-write hazard detection.
// Revision    : 1.0
// =============================================================================
module rf_wb_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int NREG   = 16
) (
    input  logic           clk,
    input  logic           rst,
    rf_wb_arbiter_if.slave bus
);
    logic              r_last;     // 0 = ALU granted last, 1 = LD granted last
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_rw;
    logic              r_wr;
    logic [NREG-1:0]   r_busy;
    logic              r_sb_err;

    logic              w_alu_rdy;
    logic              w_ld_rdy;
    logic              w_alu_go;
    logic              w_ld_go;
    logic              w_err;
    logic [NREG-1:0]   w_busy_nxt;

    // Under contention the source that did not win last time is served.
    assign w_alu_rdy = bus.alu_valid && (!bus.ld_valid || r_last);
    assign w_ld_rdy  = bus.ld_valid  && (!bus.alu_valid || !r_last);
    assign w_alu_go  = bus.alu_valid && w_alu_rdy;
    assign w_ld_go   = bus.ld_valid  && w_ld_rdy;

    always_comb begin
        w_busy_nxt = r_busy;
        if (r_wr) begin
            w_busy_nxt[r_rd] = 1'b0;
        end
        // Issue is applied after the clear so a same-cycle set wins.
        if (bus.iss_valid) begin
            w_busy_nxt[bus.iss_rd] = 1'b1;
        end
    end

    assign w_err = (bus.iss_valid && r_busy[bus.iss_rd] && !(r_wr && (r_rd == bus.iss_rd)))
                 || (r_wr && !r_busy[r_rd]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last   <= 1'b1;
            r_rd     <= '0;
            r_rw     <= '0;
            r_wr     <= 1'b0;
            r_busy   <= '0;
            r_sb_err <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_err) begin
                r_sb_err <= 1'b1;
            end
            if (w_alu_go) begin
                r_rd   <= bus.alu_rd;
                r_rw   <= bus.alu_data;
                r_wr   <= 1'b1;
                r_last <= 1'b0;
            end else if (w_ld_go) begin
                r_rd   <= bus.ld_rd;
                r_rw   <= bus.ld_data;
                r_wr   <= 1'b1;
                r_last <= 1'b1;
            end else begin
                r_wr   <= 1'b0;
            end
        end
    end

    assign bus.alu_ready = w_alu_rdy;
    assign bus.ld_ready  = w_ld_rdy;
    assign bus.hazard_s  = r_busy[bus.Rs];
    assign bus.hazard_t  = r_busy[bus.Rt];
    assign bus.Rd        = r_rd;
    assign bus.RW        = r_rw;
    assign bus.wr        = r_wr;
    assign bus.sb_err    = r_sb_err;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : tb_rf_wb_arbiter
// Description : Directed and randomized scoreboard bench for rf_wb_arbiter.
// Revision    : 1.0
// =============================================================================
module tb_rf_wb_arbiter;
    logic clk;
    logic rst;

    rf_wb_arbiter_if #(.DATA_W(16), .ADDR_W(4)) bus ();

    rf_wb_arbiter #(.DATA_W(16), .ADDR_W(4), .NREG(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  rd;
        logic [15:0] data;
    } wb_t;

    wb_t         exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    bit          chk_en   = 1'b0;

    // Reference state: what the register-file side should look like now.
    bit [15:0]   m_busy = '0;
    bit          m_last = 1'b1;
    bit          m_err  = 1'b0;
    bit          m_wr   = 1'b0;
    logic [3:0]  m_rd   = '0;
    logic [15:0] m_rw   = '0;
    bit          e_alu_rdy, e_ld_rdy, acc_alu, acc_ld;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected readies and accepted transfers for the inputs now on the bus.
    task automatic eval();
        bit both;
        both      = bus.alu_valid && bus.ld_valid;
        e_alu_rdy = both ? m_last  : bus.alu_valid;
        e_ld_rdy  = both ? !m_last : bus.ld_valid;
        acc_alu   = e_alu_rdy && !rst;
        acc_ld    = e_ld_rdy && !rst;
        if (acc_alu) exp_q.push_back({bus.alu_rd, bus.alu_data});
        if (acc_ld)  exp_q.push_back({bus.ld_rd, bus.ld_data});
    endtask

    // Advance the reference by one clock edge using the inputs of the ending cycle.
    task automatic model_edge();
        if (rst) begin
            m_busy = '0; m_last = 1'b1; m_err = 1'b0;
            m_wr = 1'b0; m_rd = '0; m_rw = '0;
        end else begin
            if (bus.iss_valid && m_busy[bus.iss_rd] && !(m_wr && m_rd == bus.iss_rd)) m_err = 1'b1;
            if (m_wr && !m_busy[m_rd]) m_err = 1'b1;
            if (m_wr) m_busy[m_rd] = 1'b0;
            if (bus.iss_valid) m_busy[bus.iss_rd] = 1'b1;
            m_wr = acc_alu || acc_ld;
            if (acc_alu) begin
                m_rd = bus.alu_rd; m_rw = bus.alu_data; m_last = 1'b0;
            end else if (acc_ld) begin
                m_rd = bus.ld_rd;  m_rw = bus.ld_data;  m_last = 1'b1;
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.ld_valid  = 1'b0;
        bus.iss_valid = 1'b0;
    endtask

    function automatic logic [3:0] pick_busy();
        int s = int'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) return 4'(s);
        for (int k = 0; k < 16; k++)
            if (m_busy[(s + k) % 16]) return 4'((s + k) % 16);
        return 4'(s);
    endfunction

    function automatic logic [3:0] pick_free();
        logic [3:0] r = 4'($urandom_range(0, 15));
        for (int k = 0; k < 3; k++)
            if (m_busy[r] && $urandom_range(0, 7) != 0) r = 4'($urandom_range(0, 15));
        return r;
    endfunction

    // Monitor: compares every cycle against the reference, pops on each write.
    always @(negedge clk) begin
        wb_t w;
        if (chk_en) begin
            chk("alu_ready", 32'(bus.alu_ready), 32'(e_alu_rdy));
            chk("ld_ready",  32'(bus.ld_ready),  32'(e_ld_rdy));
            chk("hazard_s",  32'(bus.hazard_s),  32'(m_busy[bus.Rs]));
            chk("hazard_t",  32'(bus.hazard_t),  32'(m_busy[bus.Rt]));
            chk("wr",        32'(bus.wr),        32'(m_wr));
            chk("sb_err",    32'(bus.sb_err),    32'(m_err));
            if (bus.wr === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL wb_unexpected: actual Rd=%0h RW=%0h required no write", bus.Rd, bus.RW);
                end else begin
                    w = exp_q.pop_front();
                    chk("wb_rd",   32'(bus.Rd), 32'(w.rd));
                    chk("wb_data", 32'(bus.RW), 32'(w.data));
                end
            end else begin
                chk("hold_rd", 32'(bus.Rd), 32'(m_rd));
                chk("hold_rw", 32'(bus.RW), 32'(m_rw));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with arbitrary activity on every input.
        rst = 1'b1;
        bus.alu_valid = 1'b1; bus.alu_rd = 4'd11; bus.alu_data = 16'hDEAD;
        bus.ld_valid  = 1'b1; bus.ld_rd  = 4'd12; bus.ld_data  = 16'hBEEF;
        bus.iss_valid = 1'b1; bus.iss_rd = 4'd2;  bus.Rs = 4'd2; bus.Rt = 4'd11;
        eval();
        next_cycle();
        chk_en = 1'b1;
        eval();
        next_cycle();
        chk("rst_wr", 32'(bus.wr), 32'd0);
        chk("rst_rd", 32'(bus.Rd), 32'd0);
        chk("rst_rw", 32'(bus.RW), 32'd0);
        chk("rst_sb_err", 32'(bus.sb_err), 32'd0);

        rst = 1'b0; idle();
        bus.alu_valid = 1'b1; bus.alu_rd = 4'd3; bus.alu_data = 16'h1234;
        eval();
        @(negedge clk);
        chk("first_alu_ready", 32'(bus.alu_ready), 32'd1);
        chk("rst_busy_s", 32'(bus.hazard_s), 32'd0);
        chk("rst_busy_t", 32'(bus.hazard_t), 32'd0);
        next_cycle();
        idle(); eval();
        chk("first_wr", 32'(bus.wr), 32'd1);
        chk("first_rd", 32'(bus.Rd), 32'd3);
        chk("first_rw", 32'(bus.RW), 32'h1234);
        next_cycle();

        // Contention: grants alternate starting with the ALU.
        rst = 1'b1; idle(); eval(); next_cycle(); rst = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 4'd1; bus.alu_data = 16'hAAAA;
        bus.ld_valid  = 1'b1; bus.ld_rd  = 4'd2; bus.ld_data  = 16'h5555;
        for (int i = 0; i < 6; i++) begin
            if (i >= 4) begin bus.alu_valid = 1'b0; bus.ld_valid = 1'b0; end
            eval();
            @(negedge clk);
            if (i < 4) begin
                chk("cont_alu_ready", 32'(bus.alu_ready), 32'(i % 2 == 0));
                chk("cont_ld_ready",  32'(bus.ld_ready),  32'(i % 2 == 1));
            end
            if (i >= 1 && i <= 4) chk("cont_wr", 32'(bus.wr), 32'd1);
            if (i == 5) chk("cont_wr_end", 32'(bus.wr), 32'd0);
            next_cycle();
            if (acc_alu) bus.alu_data = bus.alu_data + 16'h1111;
            if (acc_ld)  bus.ld_data  = bus.ld_data  + 16'h1111;
        end

        // Scoreboard: issue r5, load writes r5, hazard timing.
        rst = 1'b1; idle(); eval(); next_cycle(); rst = 1'b0;
        bus.iss_valid = 1'b1; bus.iss_rd = 4'd5; bus.Rs = 4'd5; bus.Rt = 4'd0;
        eval(); @(negedge clk); chk("sb_c0_haz", 32'(bus.hazard_s), 32'd0); next_cycle();
        idle(); eval(); @(negedge clk); chk("sb_c1_haz", 32'(bus.hazard_s), 32'd1); next_cycle();
        eval(); next_cycle();
        bus.ld_valid = 1'b1; bus.ld_rd = 4'd5; bus.ld_data = 16'hBEEF;
        eval(); @(negedge clk);
        chk("sb_c3_ld_ready", 32'(bus.ld_ready), 32'd1);
        chk("sb_c3_haz", 32'(bus.hazard_s), 32'd1);
        next_cycle();
        idle(); eval(); @(negedge clk);
        chk("sb_c4_wr", 32'(bus.wr), 32'd1);
        chk("sb_c4_rd", 32'(bus.Rd), 32'd5);
        chk("sb_c4_haz", 32'(bus.hazard_s), 32'd1);
        next_cycle();
        eval(); @(negedge clk);
        chk("sb_c5_haz", 32'(bus.hazard_s), 32'd0);
        chk("sb_c5_err", 32'(bus.sb_err), 32'd0);
        next_cycle();

        // Same-cycle set and clear of r7.
        bus.iss_valid = 1'b1; bus.iss_rd = 4'd7; eval(); next_cycle();
        idle(); bus.alu_valid = 1'b1; bus.alu_rd = 4'd7; bus.alu_data = 16'h0707; eval(); next_cycle();
        idle(); bus.iss_valid = 1'b1; bus.iss_rd = 4'd7; bus.Rs = 4'd7; eval();
        @(negedge clk);
        chk("sc_wr", 32'(bus.wr), 32'd1);
        chk("sc_rd", 32'(bus.Rd), 32'd7);
        next_cycle();
        idle(); eval(); @(negedge clk);
        chk("sc_busy7", 32'(bus.hazard_s), 32'd1);
        chk("sc_err", 32'(bus.sb_err), 32'd0);
        next_cycle();

        // Double issue to r9 is a protocol error, sticky until reset.
        bus.iss_valid = 1'b1; bus.iss_rd = 4'd9; eval(); next_cycle();
        eval(); next_cycle();
        idle(); eval(); @(negedge clk); chk("dbl_err", 32'(bus.sb_err), 32'd1);
        for (int i = 0; i < 3; i++) begin next_cycle(); eval(); end
        @(negedge clk); chk("dbl_err_sticky", 32'(bus.sb_err), 32'd1);
        next_cycle();
        rst = 1'b1; eval(); next_cycle(); rst = 1'b0;
        chk("dbl_err_cleared", 32'(bus.sb_err), 32'd0);

        // Write-back to a register that is not busy.
        bus.alu_valid = 1'b1; bus.alu_rd = 4'd4; bus.alu_data = 16'h4444; eval(); next_cycle();
        idle(); eval(); @(negedge clk); chk("nb_err_pre", 32'(bus.sb_err), 32'd0); next_cycle();
        eval(); chk("nb_err", 32'(bus.sb_err), 32'd1);
        next_cycle();

        // Reset in the same cycle as an ALU accept.
        idle(); bus.alu_valid = 1'b1; bus.alu_rd = 4'd6; bus.alu_data = 16'h6666; eval(); next_cycle();
        rst = 1'b1; bus.alu_data = 16'h6667; bus.iss_valid = 1'b1; bus.iss_rd = 4'd6;
        eval(); @(negedge clk); chk("rm_alu_ready", 32'(bus.alu_ready), 32'd1); next_cycle();
        rst = 1'b0; idle();
        bus.alu_valid = 1'b1; bus.ld_valid = 1'b1; bus.Rs = 4'd6;
        eval();
        chk("rm_wr", 32'(bus.wr), 32'd0);
        @(negedge clk);
        chk("rm_busy6", 32'(bus.hazard_s), 32'd0);
        chk("rm_last_alu", 32'(bus.alu_ready), 32'd1);
        chk("rm_last_ld", 32'(bus.ld_ready), 32'd0);
        next_cycle();

        // Randomized traffic; unaccepted sources hold their request.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!bus.alu_valid || acc_alu) begin
                bus.alu_valid = ($urandom_range(0, 2) != 0);
                bus.alu_rd    = pick_busy();
                bus.alu_data  = 16'($urandom);
            end
            if (!bus.ld_valid || acc_ld) begin
                bus.ld_valid = ($urandom_range(0, 2) != 0);
                bus.ld_rd    = pick_busy();
                bus.ld_data  = 16'($urandom);
            end
            bus.iss_valid = ($urandom_range(0, 2) == 0);
            bus.iss_rd    = pick_free();
            bus.Rs        = 4'($urandom_range(0, 15));
            bus.Rt        = 4'($urandom_range(0, 15));
            eval();
            next_cycle();
        end

        rst = 1'b0;
        if (bus.alu_valid && !acc_alu) bus.alu_valid = 1'b1; else bus.alu_valid = 1'b0;
        if (bus.ld_valid && !acc_ld) bus.ld_valid = 1'b1; else bus.ld_valid = 1'b0;
        bus.iss_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            eval();
            next_cycle();
            if (acc_alu) bus.alu_valid = 1'b0;
            if (acc_ld)  bus.ld_valid  = 1'b0;
        end
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and scoreboard for the 16-entry, 16-bit register file. Two write-back sources, the ALU and the load unit, share the register file's single write port through valid/ready handshakes under round-robin priority. A per-register busy scoreboard, set at issue and cleared at write-back, flags read-after-write hazards on the two read addresses so the decode stage can stall.

## Interface
Parameters:
- DATA_W, 16, write data width; matches register width.
- ADDR_W, 4, register address width.
- NREG, 16, number of registers; equals 2**ADDR_W.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result available.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU transfer accepted this cycle.
- ld_valid  in  1  load result available.
- ld_rd  in  ADDR_W  load destination register.
- ld_data  in  DATA_W  load result.
- ld_ready  out  1  load transfer accepted this cycle.
- iss_valid  in  1  instruction with a register destination issued this cycle.
- iss_rd  in  ADDR_W  destination of the issued instruction.
- Rs  in  ADDR_W  read address 1, shared with the register file.
- Rt  in  ADDR_W  read address 2, shared with the register file.
- hazard_s  out  1  busy[Rs]; combinational.
- hazard_t  out  1  busy[Rt]; combinational.
- Rd  out  ADDR_W  register-file write address; registered.
- RW  out  DATA_W  register-file write data; registered.
- wr  out  1  register-file write enable; registered.
- sb_err  out  1  sticky scoreboard protocol-error flag.

## Operation
- Transfer: a source completes a transfer in any cycle where its valid and ready are both high. Ready is combinational from the valids and the round-robin pointer.
- Arbitration:
  - Only one source valid: that source gets ready=1.
  - Both sources valid: the source not granted last gets ready=1; the other gets ready=0.
  - Pointer `last` (1 bit: 0=ALU, 1=LD) updates only on a completed transfer.
- A source whose ready is low must hold valid, rd and data stable until its transfer completes.
- Write port: on a completed transfer, the next edge loads Rd/RW with the winner's rd/data and sets wr=1. With no transfer, the next edge clears wr to 0 and holds Rd/RW.
- Scoreboard: busy[NREG-1:0].
  - iss_valid sets busy[iss_rd].
  - A cycle with wr=1 clears busy[Rd] at the closing edge.
  - Set and clear of the same register in the same cycle: set wins.
- Hazards: hazard_s=busy[Rs] and hazard_t=busy[Rt], with no bypass. During the cycle wr=1 the bit is still set; the register file latches the value at that same edge, so the read in the following cycle is clean.
- sb_err is set, and held until reset, on either condition:
  - iss_valid to a register already busy, unless that register is being cleared in the same cycle.
  - wr=1 to a register whose busy bit is clear.
- The offending update still takes effect.

## Timing
- Reset values: Rd=0, RW=0, wr=0, busy=0, last=1 (ALU wins the first contention), sb_err=0. alu_ready and ld_ready follow the valids after reset with no extra delay.
- Reset is synchronous and overrides every same-edge update, including a mid-transfer accept. A transfer accepted in the reset cycle is dropped and never written.
- Latency: transfer at edge N produces wr=1 in cycle N+1. Busy clears at the end of cycle N+1, so hazard drops in cycle N+2.
- Throughput: one write per cycle. Under continuous dual contention the grants alternate ALU, LD, ALU, ...
- Issue-to-hazard: iss_valid in cycle N gives hazard=1 from cycle N+1.

## Test plan
- Reset: drive arbitrary inputs with rst=1 for 2 cycles → wr=0, Rd=0, RW=0, busy=0, sb_err=0. Then alu_valid=1, alu_rd=3, alu_data=16'h1234 → alu_ready=1; next cycle wr=1, Rd=3, RW=16'h1234.
- Contention: both valid for 4 cycles (alu_rd=1/16'hAAAA, ld_rd=2/16'h5555, new data after each accept) → grants ALU, LD, ALU, LD; the losing ready is 0 each cycle; wr stays 1 for 4 consecutive cycles.
- Scoreboard: iss_valid with iss_rd=5 in cycle 0; Rs=5 → hazard_s=1 from cycle 1. LD writes r5 (accept cycle 3) → wr=1 in cycle 4 with hazard_s=1; hazard_s=0 in cycle 5.
- Same-cycle set/clear: wr=1 to r7 while iss_valid with iss_rd=7 → busy[7] remains 1, sb_err stays 0.
- Protocol error: iss_valid to r9 twice with no write-back between → sb_err=1 and stays 1 until rst. Separately, a write-back to a non-busy r4 → sb_err=1.
- Reset mid-operation: rst=1 in the same cycle alu_valid and alu_ready are 1 (alu_rd=6) → next cycle wr=0, busy[6]=0, last=1.
